// File: rtl/restador_serie_4_bits.sv
// Bit-serial 4-bit adder/subtractor.
// One full-adder cell processes the operands LSB first over four clock edges.
// M=1 selects A-B in two's complement: B is inverted on load and the carry
// flip-flop is seeded with 1.
// Result, final carry and signed overflow are registered on the last serial
// edge and held until the next operation completes.
module restador_serie_4_bits (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       M,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic       ready,
  output logic       done,
  output logic [3:0] Resultado,
  output logic       C4,
  output logic       V
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] ra_q, ra_d;
  logic [3:0] rb_q, rb_d;
  logic [3:0] rs_q, rs_d;
  logic       q_q, q_d;
  logic [1:0] cnt_q, cnt_d;
  logic [3:0] res_q, res_d;
  logic       c4_q, c4_d;
  logic       v_q, v_d;

  logic       fa_s;
  logic       fa_cout;

  // Single full-adder cell on the current LSBs and the carry flip-flop.
  always_comb begin
    fa_s    = ra_q[0] ^ rb_q[0] ^ q_q;
    fa_cout = (ra_q[0] & rb_q[0]) | (ra_q[0] & q_q) | (rb_q[0] & q_q);
  end

  // State and datapath registers; reset clears everything and returns to IDLE.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      rs_q    <= '0;
      q_q     <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      c4_q    <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rs_q    <= rs_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      c4_q    <= c4_d;
      v_q     <= v_d;
    end
  end

  // Next-state and datapath update; every register holds unless its state acts.
  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rs_d    = rs_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    c4_d    = c4_q;
    v_d     = v_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          ra_d    = A;
          rb_d    = B ^ {4{M}};
          q_d     = M;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        ra_d  = {1'b0, ra_q[3:1]};
        rb_d  = {1'b0, rb_q[3:1]};
        rs_d  = {fa_s, rs_q[3:1]};
        q_d   = fa_cout;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          // q_q still holds the carry into bit 3 on this edge.
          res_d   = {fa_s, rs_q[3:1]};
          c4_d    = fa_cout;
          v_d     = fa_cout ^ q_q;
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake and result outputs.
  always_comb begin
    ready     = (state_q == IDLE);
    done      = (state_q == DONE);
    Resultado = res_q;
    C4        = c4_q;
    V         = v_q;
  end

endmodule

// File: doc/restador_serie_4_bits.md
RESTADOR_SERIE_4_BITS -- requirements
Module: restador_serie_4_bits

Interface
REQ-001 SHALL have parameter: none; operand width fixed at 4 bits.
REQ-002 SHALL have port: clock  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request; sampled only while ready=1.
REQ-005 SHALL have port: M  input  1  mode; 0 = A+B, 1 = A-B (two's complement); sampled with start.
REQ-006 SHALL have port: A  input  4  first operand (minuend/addend); sampled with start.
REQ-007 SHALL have port: B  input  4  second operand (subtrahend/addend); sampled with start.
REQ-008 SHALL have port: ready  output  1  high only in IDLE.
REQ-009 SHALL have port: done  output  1  one-cycle pulse; result valid.
REQ-010 SHALL have port: Resultado  output  4  sum/difference.
REQ-011 SHALL have port: C4  output  1  final carry; in subtract mode 1 = no borrow (A>=B unsigned), 0 = borrow.
REQ-012 SHALL have port: V  output  1  signed overflow.

Function
REQ-013 SHALL be bit-serial: one full-adder cell, 4-bit shift registers RA, RB, RS, carry flip-flop Q, 2-bit bit counter.
REQ-014 SHALL implement FSM states IDLE, SHIFT, DONE; no other reachable states.
REQ-015 IDLE: ready=1; on edge with start=1 SHALL load RA<=A, RB<=B XOR {4{M}}, Q<=M, counter<=0, go SHIFT.
REQ-016 IDLE with start=0 SHALL hold all registers and outputs.
REQ-017 SHIFT: each edge SHALL compute s = RA[0]^RB[0]^Q, cout = majority(RA[0],RB[0],Q); RA, RB shift right; s enters RS[3]; Q<=cout; counter+1.
REQ-018 SHALL stay in SHIFT exactly 4 edges; on the edge where counter=3 SHALL go DONE.
REQ-019 On that 4th SHIFT edge SHALL register Resultado<=final RS (LSB-first bits in order), C4<=cout, V<=cout XOR carry-in of bit 3.
REQ-020 DONE: done=1, ready=0 for exactly one cycle; next edge SHALL return to IDLE.
REQ-021 Latency: start sampled at edge E0 -> done high in cycle between E4 and E5; ready high again after E5.
REQ-022 start, A, B, M SHALL be ignored while in SHIFT or DONE; no queuing.
REQ-023 Resultado, C4, V SHALL hold their values from DONE until next completed operation; SHALL NOT change during SHIFT.
REQ-024 Back-to-back: start=1 in first IDLE cycle after DONE SHALL be accepted; minimum period 6 cycles per operation.
REQ-025 Arithmetic SHALL be modulo 16; C4 and V computed per REQ-019 for both modes.

Reset
REQ-026 reset=1 at an edge SHALL force state IDLE, RA=RB=RS=0, Q=0, counter=0, Resultado=0, C4=0, V=0, done=0; ready=1 from next cycle.
REQ-027 reset SHALL take priority over start and over any SHIFT/DONE activity; an aborted operation SHALL produce no done pulse.
REQ-028 Out of reset the block SHALL accept start on the first edge with reset=0.

Verification
REQ-029 M=1, A=0101, B=0011, start -> after 5 edges done=1, Resultado=0010, C4=1, V=0.
REQ-030 M=1, A=0011, B=0101 -> Resultado=1110, C4=0 (borrow), V=0; M=1, A=1000, B=0001 -> Resultado=0111, C4=1, V=1.
REQ-031 M=0, A=0111, B=0001 -> Resultado=1000, C4=0, V=1; M=0, A=1111, B=0001 -> Resultado=0000, C4=1, V=0.
REQ-032 reset=1 on 2nd SHIFT edge -> IDLE, all outputs 0, no done pulse; subsequent 0101-0011 yields 0010 correctly.
REQ-033 start toggled with new A/B every cycle during SHIFT/DONE -> result reflects only operands sampled at E0; exactly one done per accepted start.
REQ-034 Two operations back-to-back (start held high) -> done pulses 6 cycles apart, each with correct Resultado/C4/V; outputs stable between pulses.
